// File: rtl/response_collector_if.sv
// Bus bundle between the evaluation controller/consumer and response_collector.
// The controller side drives the store strobe, eval_done and resp_ready; the
// collector side returns the response handshake and status flags.
interface response_collector_if #(
    parameter int NUM_LOOPS = 4,
    parameter int CNT_BITS  = 32
);
    localparam int SEL_W = (NUM_LOOPS > 2) ? $clog2(NUM_LOOPS) : 1;
    localparam int NPAIR = NUM_LOOPS / 2;

    logic                store_response_puf;
    logic [SEL_W-1:0]    select_puf;
    logic [CNT_BITS-1:0] puf_count;
    logic                eval_done;
    logic                resp_ready;
    logic                resp_valid;
    logic [NPAIR-1:0]    response;
    logic                resp_error;
    logic                busy;
    logic                dropped;

    modport master (
        output store_response_puf,
        output select_puf,
        output puf_count,
        output eval_done,
        output resp_ready,
        input  resp_valid,
        input  response,
        input  resp_error,
        input  busy,
        input  dropped
    );

    modport slave (
        input  store_response_puf,
        input  select_puf,
        input  puf_count,
        input  eval_done,
        input  resp_ready,
        output resp_valid,
        output response,
        output resp_error,
        output busy,
        output dropped
    );
endinterface

// File: rtl/response_collector.sv
// Collects averaged TERO loop frequencies, compares loop pairs one per cycle
// once evaluation finishes, and presents the PUF response with a valid/ready
// handshake. Strobes that cannot be honoured are flagged on a sticky output.
// The interface instance must use the same NUM_LOOPS/CNT_BITS as this module.
module response_collector #(
    parameter int NUM_LOOPS = 4,
    parameter int CNT_BITS  = 32,
    parameter int AVG_SHIFT = 12,
    parameter int FREQ_BITS = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    response_collector_if.slave    bus
);
    localparam int SEL_W  = (NUM_LOOPS > 2) ? $clog2(NUM_LOOPS) : 1;
    localparam int NPAIR  = NUM_LOOPS / 2;
    localparam int PAIR_W = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NPAIR - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPARE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // FSM decoded controls
    logic collect_en;
    logic start_compare;
    logic compare_en;
    logic finish_compare;
    logic handshake;
    logic busy_o;

    // Evaluation-done edge detection
    logic eval_done_reg;
    logic eval_rise;

    // Capture path
    logic [NUM_LOOPS-1:0] sel_hit;
    logic                 sel_in_range;
    logic                 store_en;
    logic                 drop_event;
    logic [CNT_BITS-1:0]  count_shifted;
    logic [FREQ_BITS-1:0] freq_in;
    logic [FREQ_BITS-1:0] freq_reg [NUM_LOOPS];
    logic [NUM_LOOPS-1:0] captured_reg;

    // Compare path
    logic [PAIR_W-1:0]    pair_reg;
    logic [NPAIR-1:0]     pair_hit;
    logic [SEL_W-1:0]     idx_a;
    logic [SEL_W-1:0]     idx_b;
    logic [FREQ_BITS-1:0] freq_a;
    logic [FREQ_BITS-1:0] freq_b;
    logic                 pair_ok;
    logic                 cmp_bit;

    // Output registers
    logic [NPAIR-1:0]     response_reg;
    logic                 resp_valid_reg;
    logic                 resp_error_reg;
    logic                 dropped_reg;

    // ------------------------------------------------------------------
    // Index decode: one-hot hit per stored loop, and per-pair select for
    // the response bit currently being evaluated. An index beyond the last
    // loop produces no hit, which is how out-of-range strobes are detected.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_LOOPS; gi++) begin : g_sel
            assign sel_hit[gi] = (bus.select_puf == SEL_W'(gi));
        end
        for (gi = 0; gi < NPAIR; gi++) begin : g_pair
            assign pair_hit[gi] = (pair_reg == PAIR_W'(gi));
        end
    endgenerate

    assign sel_in_range = |sel_hit;
    assign eval_rise    = bus.eval_done & ~eval_done_reg;
    assign store_en     = collect_en & bus.store_response_puf & sel_in_range;
    assign drop_event   = bus.store_response_puf & ~(collect_en & sel_in_range);

    // ------------------------------------------------------------------
    // Averaging: divide by the repetition count, clamp to the stored width
    // when the counter has more significant bits than a frequency slot.
    // ------------------------------------------------------------------
    assign count_shifted = bus.puf_count >> AVG_SHIFT;

    generate
        if (CNT_BITS > FREQ_BITS) begin : g_sat
            logic overflow;
            assign overflow = |count_shifted[CNT_BITS-1:FREQ_BITS];
            assign freq_in  = overflow ? {FREQ_BITS{1'b1}} : count_shifted[FREQ_BITS-1:0];
        end else begin : g_nosat
            assign freq_in = FREQ_BITS'(count_shifted);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pair comparison: a single comparator walks pairs (2k, 2k+1).
    // An incomplete pair forces its bit to 0 and flags an error.
    // ------------------------------------------------------------------
    assign idx_a   = SEL_W'({pair_reg, 1'b0});
    assign idx_b   = idx_a | SEL_W'(1);
    assign freq_a  = freq_reg[idx_a];
    assign freq_b  = freq_reg[idx_b];
    assign pair_ok = captured_reg[idx_a] & captured_reg[idx_b];
    assign cmp_bit = pair_ok & (freq_a > freq_b);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: if (eval_rise) state_next = COMPARE;
            COMPARE: if (pair_reg == LAST_PAIR) state_next = OUTPUT;
            OUTPUT:  if (resp_valid_reg && bus.resp_ready) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // FSM: decoded controls per state
    always_comb begin
        collect_en     = 1'b0;
        start_compare  = 1'b0;
        compare_en     = 1'b0;
        finish_compare = 1'b0;
        handshake      = 1'b0;
        busy_o         = 1'b0;
        case (state_reg)
            COLLECT: begin
                collect_en    = 1'b1;
                start_compare = eval_rise;
            end
            COMPARE: begin
                busy_o         = 1'b1;
                compare_en     = 1'b1;
                finish_compare = (pair_reg == LAST_PAIR);
            end
            OUTPUT: begin
                busy_o    = 1'b1;
                handshake = resp_valid_reg & bus.resp_ready;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    // Register eval_done every cycle so a held level never looks like a new edge
    always_ff @(posedge clk) begin
        if (reset) begin
            eval_done_reg <= 1'b0;
        end else begin
            eval_done_reg <= bus.eval_done;
        end
    end

    // Frequency storage; last write to an index wins, contents not reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LOOPS; i++) begin
            if (store_en && sel_hit[i]) begin
                freq_reg[i] <= freq_in;
            end
        end
    end

    // Track which loops have a valid measurement for the current run
    always_ff @(posedge clk) begin
        if (reset || handshake) begin
            captured_reg <= '0;
        end else if (store_en) begin
            captured_reg <= captured_reg | sel_hit;
        end
    end

    // Pair walk counter
    always_ff @(posedge clk) begin
        if (reset || start_compare) begin
            pair_reg <= '0;
        end else if (compare_en) begin
            pair_reg <= pair_reg + PAIR_W'(1);
        end
    end

    // Response bits are built up one pair per cycle and then held
    always_ff @(posedge clk) begin
        if (reset || start_compare) begin
            response_reg <= '0;
        end else if (compare_en) begin
            response_reg <= response_reg | (pair_hit & {NPAIR{cmp_bit}});
        end
    end

    // Error flag accumulates over all pairs and is cleared by the handshake
    always_ff @(posedge clk) begin
        if (reset || start_compare || handshake) begin
            resp_error_reg <= 1'b0;
        end else if (compare_en && !pair_ok) begin
            resp_error_reg <= 1'b1;
        end
    end

    // Valid rises with the last pair and drops on acceptance
    always_ff @(posedge clk) begin
        if (reset || handshake) begin
            resp_valid_reg <= 1'b0;
        end else if (finish_compare) begin
            resp_valid_reg <= 1'b1;
        end
    end

    // Sticky record of any strobe that could not be stored
    always_ff @(posedge clk) begin
        if (reset) begin
            dropped_reg <= 1'b0;
        end else if (drop_event) begin
            dropped_reg <= 1'b1;
        end
    end

    assign bus.resp_valid = resp_valid_reg;
    assign bus.response   = response_reg;
    assign bus.resp_error = resp_error_reg;
    assign bus.busy       = busy_o;
    assign bus.dropped    = dropped_reg;

endmodule

// File: tb/tb_response_collector.sv
// Testbench for response_collector: directed scenarios with literal
// expectations plus randomized runs checked each cycle against a
// behavioural model of the collector.
module tb_response_collector;
    localparam int N  = 4;
    localparam int NP = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    response_collector_if #(.NUM_LOOPS(4), .CNT_BITS(32)) bus ();
    response_collector_if #(.NUM_LOOPS(6), .CNT_BITS(32)) bus2 ();

    response_collector #(.NUM_LOOPS(4), .CNT_BITS(32), .AVG_SHIFT(12), .FREQ_BITS(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Second instance: non power-of-two loop count and narrow slots, to
    // reach out-of-range indices and real saturation.
    response_collector #(.NUM_LOOPS(6), .CNT_BITS(32), .AVG_SHIFT(12), .FREQ_BITS(16)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of dut ----------------
    typedef enum {M_COLLECT, M_COMPARE, M_OUTPUT} mmode_t;
    mmode_t  m_mode = M_COLLECT;
    int      m_freq [N];
    bit      m_cap  [N];
    bit      m_drop = 0, m_valid = 0, m_err = 0, m_ed_prev = 0, m_pend_err = 0;
    bit [NP-1:0] m_resp = '0, m_pend_resp = '0;
    int      m_left = 0;

    function automatic int avg20(input logic [31:0] c);
        longint sh;
        sh = longint'(c) >> 12;
        if (sh > 64'hFFFFF) sh = 64'hFFFFF;
        return int'(sh);
    endfunction

    always @(posedge clk) begin : model
        bit rise;
        int sel;
        if (reset) begin
            m_mode = M_COLLECT; m_valid = 0; m_err = 0; m_resp = '0;
            m_drop = 0; m_ed_prev = 0;
            for (int i = 0; i < N; i++) m_cap[i] = 0;
        end else begin
            rise = bus.eval_done && !m_ed_prev;
            m_ed_prev = bus.eval_done;
            sel = int'(bus.select_puf);
            case (m_mode)
                M_COLLECT: begin
                    if (bus.store_response_puf) begin
                        if (sel < N) begin
                            m_freq[sel] = avg20(bus.puf_count);
                            m_cap[sel]  = 1;
                        end else begin
                            m_drop = 1;
                        end
                    end
                    if (rise) begin
                        m_pend_err = 0;
                        for (int k = 0; k < NP; k++) begin
                            if (m_cap[2*k] && m_cap[2*k+1]) begin
                                m_pend_resp[k] = (m_freq[2*k] > m_freq[2*k+1]);
                            end else begin
                                m_pend_resp[k] = 0;
                                m_pend_err = 1;
                            end
                        end
                        m_left = NP;
                        m_mode = M_COMPARE;
                    end
                end
                M_COMPARE: begin
                    if (bus.store_response_puf) m_drop = 1;
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = M_OUTPUT; m_valid = 1;
                        m_resp = m_pend_resp; m_err = m_pend_err;
                    end
                end
                default: begin
                    if (bus.store_response_puf) m_drop = 1;
                    if (bus.resp_ready) begin
                        m_valid = 0; m_err = 0; m_mode = M_COLLECT;
                        for (int i = 0; i < N; i++) m_cap[i] = 0;
                    end
                end
            endcase
        end
    end

    // Compare dut against the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, bus.busy}, {31'd0, m_mode != M_COLLECT});
            check("resp_valid", {31'd0, bus.resp_valid}, {31'd0, m_valid});
            check("dropped", {31'd0, bus.dropped}, {31'd0, m_drop});
            if (m_valid) begin
                check("response", {30'd0, bus.response}, {30'd0, m_resp});
                check("resp_error", {31'd0, bus.resp_error}, {31'd0, m_err});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int idx, input logic [31:0] cnt);
        bus.store_response_puf = 1'b1;
        bus.select_puf = 2'(idx);
        bus.puf_count = cnt;
        tick();
        bus.store_response_puf = 1'b0;
    endtask

    task automatic strobe2(input int idx, input logic [31:0] cnt);
        bus2.store_response_puf = 1'b1;
        bus2.select_puf = 3'(idx);
        bus2.puf_count = cnt;
        tick();
        bus2.store_response_puf = 1'b0;
    endtask

    // Raise eval_done and count cycles until resp_valid shows (bounded)
    task automatic eval_wait(output int n);
        bus.eval_done = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.resp_valid && n < 20);
    endtask

    task automatic finish_run();
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        bus.eval_done = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] rnd_count();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = 32'hFFFF_FFFF;
            default: v = (32'($urandom_range(0, 6)) << 12) | 32'($urandom_range(0, 4095));
        endcase
        return v;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        bus.store_response_puf = 0; bus.select_puf = '0; bus.puf_count = '0;
        bus.eval_done = 0; bus.resp_ready = 0;
        bus2.store_response_puf = 0; bus2.select_puf = '0; bus2.puf_count = '0;
        bus2.eval_done = 0; bus2.resp_ready = 0;

        // Reset state
        reset = 1'b1;
        tick(); tick();
        check("rst_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_dropped", {31'd0, bus.dropped}, 32'd0);
        check("rst_response", {30'd0, bus.response}, 32'd0);
        check("rst_error", {31'd0, bus.resp_error}, 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;
        tick();

        // Basic run: 5>4 -> 1, tie 3=3 -> 0
        strobe(0, 32'h5000); strobe(1, 32'h4000); strobe(2, 32'h3000); strobe(3, 32'h3000);
        eval_wait(n);
        check("A_latency", n, 32'd3);
        check("A_response", {30'd0, bus.response}, 32'h1);
        check("A_error", {31'd0, bus.resp_error}, 32'd0);

        // Back-pressure: outputs hold for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("hold_response", {30'd0, bus.response}, 32'h1);
        end

        // Strobe during OUTPUT is dropped
        check("pre_drop", {31'd0, bus.dropped}, 32'd0);
        strobe(1, 32'h7FFF_F000);
        check("out_drop", {31'd0, bus.dropped}, 32'd1);
        check("out_drop_valid", {31'd0, bus.resp_valid}, 32'd1);

        // Handshake with eval_done still high: no new compare
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("hs_valid", {31'd0, bus.resp_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_retrigger", {31'd0, bus.busy}, 32'd0);
        end
        bus.eval_done = 1'b0;
        tick();

        // Incomplete pair
        strobe(0, 32'h9000); strobe(1, 32'h2000);
        eval_wait(n);
        check("B_latency", n, 32'd3);
        check("B_error", {31'd0, bus.resp_error}, 32'd1);
        check("B_bit1", {31'd0, bus.response[1]}, 32'd0);
        check("B_response", {30'd0, bus.response}, 32'h1);
        finish_run();

        // Reset in the middle of COMPARE
        strobe(0, 32'h1000); strobe(1, 32'h2000); strobe(2, 32'h8000); strobe(3, 32'h7000);
        bus.eval_done = 1'b1;
        tick();
        check("C_busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        bus.eval_done = 1'b0;
        tick();
        check("C_rst_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("C_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("C_rst_response", {30'd0, bus.response}, 32'd0);
        check("C_rst_error", {31'd0, bus.resp_error}, 32'd0);
        check("C_rst_dropped", {31'd0, bus.dropped}, 32'd0);
        reset = 1'b0;
        tick();
        strobe(0, 32'h1000); strobe(1, 32'h2000); strobe(2, 32'h8000); strobe(3, 32'h7000);
        eval_wait(n);
        check("C_latency", n, 32'd3);
        check("C_response", {30'd0, bus.response}, 32'h2);
        check("C_error", {31'd0, bus.resp_error}, 32'd0);
        finish_run();

        // Randomized runs against the model
        for (int r = 0; r < 40; r++) begin
            int ns;
            int w;
            ns = $urandom_range(0, 6);
            for (int s = 0; s < ns; s++) begin
                strobe($urandom_range(0, 3), rnd_count());
                if ($urandom_range(0, 2) == 0) tick();
            end
            bus.eval_done = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                bus.store_response_puf = 1'b1;
                bus.select_puf = 2'($urandom_range(0, 3));
                bus.puf_count = rnd_count();
            end
            tick();
            n = 1;
            while (!bus.resp_valid && n < 20) begin
                bus.store_response_puf = ($urandom_range(0, 3) == 0);
                bus.select_puf = 2'($urandom_range(0, 3));
                bus.puf_count = rnd_count();
                tick();
                n++;
            end
            bus.store_response_puf = 1'b0;
            check("rand_latency", n, 32'd3);
            w = $urandom_range(0, 3);
            repeat (w) tick();
            bus.eval_done = ($urandom_range(0, 1) == 1);
            finish_run();
        end

        // Second instance: saturation, out-of-range index, six loops
        chk_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        strobe2(0, 32'h2000_0000);
        strobe2(1, 32'h0FFF_E000);
        strobe2(2, 32'h0000_1000);
        check("D_drop_before", {31'd0, bus2.dropped}, 32'd0);
        strobe2(7, 32'h9999_0000);
        check("D_drop_oor", {31'd0, bus2.dropped}, 32'd1);
        strobe2(4, 32'h5000);
        strobe2(5, 32'h6000);
        bus2.eval_done = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus2.resp_valid && n < 20);
        check("D_latency", n, 32'd4);
        check("D_response", {29'd0, bus2.response}, 32'h1);
        check("D_error", {31'd0, bus2.resp_error}, 32'd1);
        bus2.resp_ready = 1'b1;
        tick();
        bus2.resp_ready = 1'b0;
        bus2.eval_done = 1'b0;
        tick();
        check("D_hs_valid", {31'd0, bus2.resp_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/response_collector.md
RESPONSE_COLLECTOR -- requirements
Module: response_collector

Interface
REQ-001 SHALL have parameter NUM_LOOPS, default 4: number of TERO loops; even, >=2.
REQ-002 SHALL have parameter CNT_BITS, default 32: width of the shared oscillation counter.
REQ-003 SHALL have parameter AVG_SHIFT, default 12: right shift applied to the counter; equals log2(REPETITIONS).
REQ-004 SHALL have parameter FREQ_BITS, default 20: width of each stored averaged frequency.
REQ-005 SHALL define SEL_W = max(1, clog2(NUM_LOOPS)) and NPAIR = NUM_LOOPS/2.
REQ-006 SHALL have port clk, input, 1: global clock, rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high.
REQ-008 SHALL have port store_response_puf, input, 1: one-cycle strobe; puf_count and select_puf are valid only in this cycle.
REQ-009 SHALL have port select_puf, input, SEL_W: index of the loop being stored.
REQ-010 SHALL have port puf_count, input, CNT_BITS: accumulated oscillations of the selected loop.
REQ-011 SHALL have port eval_done, input, 1: level "done" from the evaluation FSM.
REQ-012 SHALL have port resp_ready, input, 1: consumer accepts the response.
REQ-013 SHALL have port resp_valid, output, 1: response and resp_error are valid.
REQ-014 SHALL have port response, output, NPAIR: one bit per loop pair.
REQ-015 SHALL have port resp_error, output, 1: at least one pair was incomplete.
REQ-016 SHALL have port busy, output, 1: high in COMPARE and OUTPUT.
REQ-017 SHALL have port dropped, output, 1: sticky; a strobe was ignored.

Function
REQ-018 SHALL implement states COLLECT, COMPARE and OUTPUT.
REQ-019 SHALL, in COLLECT when store_response_puf=1, write freq[select_puf] = puf_count >> AVG_SHIFT on the next edge and set captured[select_puf].
REQ-020 SHALL saturate freq to 2^FREQ_BITS-1 when the shifted value exceeds FREQ_BITS.
REQ-021 SHALL ignore the strobe when select_puf >= NUM_LOOPS and set dropped.
REQ-022 SHALL, when the same index is strobed again, overwrite the stored value (last write wins).
REQ-023 SHALL register eval_done and move COLLECT->COMPARE on its rising edge only; a level held high SHALL NOT retrigger.
REQ-024 SHALL, when a strobe and the eval_done rising edge occur in the same cycle, capture the strobe before COMPARE begins.
REQ-025 SHALL, in COMPARE, evaluate one pair per cycle, k = 0..NPAIR-1, with response[k] = (freq[2k] > freq[2k+1]); ties give 0.
REQ-026 SHALL set resp_error if captured[2k] or captured[2k+1] is 0 for any k; the affected bit SHALL be 0.
REQ-027 SHALL enter OUTPUT after the last pair; resp_valid SHALL rise exactly NPAIR+1 cycles after the cycle in which eval_done is first high.
REQ-028 SHALL hold resp_valid, response and resp_error stable in OUTPUT until resp_valid & resp_ready.
REQ-029 SHALL, on the handshake, clear captured, resp_valid and resp_error, and return to COLLECT in the next cycle.
REQ-030 SHALL ignore strobes in COMPARE and OUTPUT and set dropped.
REQ-031 SHALL clear dropped only on reset.

Reset
REQ-032 SHALL, while reset=1, on each edge: state=COLLECT; resp_valid=0; response=0; resp_error=0; busy=0; dropped=0; captured=0; registered eval_done=0. freq contents are don't-care.
REQ-033 SHALL, when reset is asserted in any state, abort the operation with no handshake and discard all stored data.

Verification
REQ-034 Bench: NUM_LOOPS=4, AVG_SHIFT=12; strobes idx0..3 with counts 0x5000, 0x4000, 0x3000, 0x3000, then eval_done -> response=2'b01, resp_error=0, resp_valid 3 cycles after eval_done rises.
REQ-035 Bench: strobe only idx0 and idx1, then eval_done -> resp_error=1, response[1]=0.
REQ-036 Bench: hold resp_ready=0 for 10 cycles -> outputs stable; on resp_ready=1 the handshake completes, and eval_done still high -> no new COMPARE.
REQ-037 Bench: strobe during OUTPUT, and a strobe with select_puf=5 when NUM_LOOPS=8 is changed to 4 -> dropped=1, stored values unchanged.
REQ-038 Bench: puf_count=0xFFFFFFFF -> stored freq=0xFFFFF (saturated).
REQ-039 Bench: reset asserted mid-COMPARE -> all outputs 0 on the next cycle; a fresh run gives the correct response.
